mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 32-bit five-stage MIPS pipeline. Consumes the EX/MEM register outputs, drives a word-wide data-memory bus with a req/ack handshake and a bounded wait timeout, and holds the upstream pipeline while an access is outstanding. Flags misaligned and timed-out accesses, and registers results into the MEM/WB register consumed by write-back.

## Interface
Parameters:
- TIMEOUT_CYC, 16: maximum cycles spent in WAIT before an access is aborted; legal range 2..255.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_regwrite  in  1  EX/MEM control: instruction writes a register
- mem_memread  in  1  EX/MEM control: load
- mem_memwrite  in  1  EX/MEM control: store
- mem_memtoreg  in  1  EX/MEM control: write-back selects memory data
- mem_alu_result  in  32  effective address / ALU result
- mem_rt_data  in  32  store data
- mem_rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  byte address, always word aligned when dmem_req = 1
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  read data, valid when dmem_ack = 1
- dmem_ack  in  1  bus completion, single cycle
- mem_stall  out  1  freeze EX/MEM and all earlier stages
- wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control
- wb_alu_result  out  32  registered ALU result
- wb_mem_data  out  32  registered load data
- wb_rd  out  5  registered destination
- mem_exc  out  1  one-cycle exception pulse
- mem_exc_cause  out  2  01 misaligned, 10 bus timeout, 00 otherwise
- mem_exc_addr  out  32  faulting address

## Operation
- access = mem_memread | mem_memwrite. If both are set, the access is a write, and the read data is discarded.
- misaligned = access & (mem_alu_result[1:0] != 0). A misaligned access never raises dmem_req and never stalls. It completes the same cycle as a fault.
- FSM states:
  - IDLE to WAIT: aligned access with no dmem_ack that cycle.
  - IDLE to IDLE: aligned access with dmem_ack the same cycle (zero-wait completion).
  - WAIT to IDLE: on dmem_ack (completion).
  - WAIT to IDLE: when wait_cnt = TIMEOUT_CYC-1 and no ack (timeout fault).
- wait_cnt is 8 bits. It clears on entry to WAIT and increments each WAIT cycle.
- dmem_req = !rst & access & !misaligned & (state==IDLE | state==WAIT). dmem_addr = mem_alu_result, dmem_wdata = mem_rt_data, dmem_we = mem_memwrite. All are combinational from EX/MEM, which stays frozen by mem_stall.
- mem_stall = dmem_req & !dmem_ack & !timeout_fire.
- MEM/WB load when mem_stall = 0:
  - wb_regwrite <= mem_regwrite & !fault
  - wb_memtoreg <= mem_memtoreg
  - wb_alu_result <= mem_alu_result
  - wb_mem_data <= dmem_rdata on read completion, else 0
  - wb_rd <= mem_rd
- While mem_stall = 1: wb_regwrite <= 0 (bubble); the other MEM/WB fields hold.
- A fault (misaligned or timeout) produces these registered values the next cycle:
  - mem_exc = 1
  - mem_exc_cause = the fault cause
  - mem_exc_addr = mem_alu_result
- Store with fault: no write reaches memory on misalignment. For a timeout the write is abandoned, and a late ack arriving in IDLE with no request is ignored.

## Timing
- Reset: state IDLE, wait_cnt 0. Every registered output is 0: wb_regwrite, wb_memtoreg, wb_alu_result, wb_mem_data, wb_rd, mem_exc, mem_exc_cause, mem_exc_addr. dmem_req and mem_stall are forced 0 while rst = 1. Reset mid-WAIT aborts the access with no exception.
- Non-memory instruction: 1-cycle latency to MEM/WB, no stall.
- Zero-wait access (ack in the request cycle): no stall, MEM/WB valid the next edge.
- Access acked after N wait cycles: mem_stall high for N cycles, N bubbles into WB, result loaded on the ack edge.
- Timeout: mem_stall high for TIMEOUT_CYC cycles. mem_exc pulses the cycle after the fire edge.
- mem_exc is never high for two consecutive cycles for one instruction.

## Structure
- Shared package mips_pkg holds:
  - FSM state encoding ST_IDLE / ST_WAIT
  - exception causes EXC_NONE=2'b00, EXC_MISALIGN=2'b01, EXC_BUSTO=2'b10
  - default TIMEOUT_CYC
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register with load enable and bubble insert. The FSM, counter and bus logic stay in mem_stage.

## Test plan
- Load, mem_alu_result=0x100, ack same cycle, rdata=0xDEADBEEF, regwrite=1, rd=5 -> no stall; next cycle wb_mem_data=0xDEADBEEF, wb_rd=5, wb_regwrite=1.
- Store, addr=0x204, ack after 3 wait cycles -> dmem_req/dmem_we high 4 cycles, mem_stall high 3 cycles, wdata stable = mem_rt_data, 3 WB bubbles.
- Load at addr=0x102 -> dmem_req never asserts, no stall, wb_regwrite=0, mem_exc pulse with cause 01, mem_exc_addr=0x102.
- Load with ack never returned, TIMEOUT_CYC=4 -> stall exactly 4 cycles, then mem_exc cause 10, wb_regwrite=0; a stray ack afterwards has no effect.
- rst asserted on the 2nd WAIT cycle -> next cycle all outputs 0, state IDLE, no mem_exc.
- Back-to-back ALU op, load (zero-wait), store (1 wait) -> correct MEM/WB sequence with exactly one bubble.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: MEM-stage FSM encoding, exception
// causes, default bus timeout and the MEM/WB register payload.
package mips_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_BUSTO    = 2'b10;

    localparam int unsigned TIMEOUT_CYC_DEF = 16;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
    } mem_wb_t;

    function automatic logic is_misaligned(input logic access, input logic [31:0] addr);
        return access && (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads when not stalled, otherwise inserts a
// bubble by clearing regwrite while the remaining fields hold.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    stall,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (stall) begin
            q.regwrite <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: word data-memory bus with req/ack handshake and bounded
// wait, misalignment/timeout faults, and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_regwrite,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic        mem_memtoreg,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rt_data,
    input  logic [4:0]  mem_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_rd,
    output logic        mem_exc,
    output logic [1:0]  mem_exc_cause,
    output logic [31:0] mem_exc_addr
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [0:0] state;
    logic [7:0] wait_cnt;
    logic       access;
    logic       misaligned;
    logic       timeout_fire;
    logic       fault;
    logic       read_done;
    mem_wb_t    wb_d;
    mem_wb_t    wb_q;

    assign access     = mem_memread | mem_memwrite;
    assign misaligned = is_misaligned(access, mem_alu_result);

    // State is only ever IDLE or WAIT, so the request needs no state term.
    assign dmem_req   = !rst && access && !misaligned;
    assign dmem_we    = mem_memwrite;
    assign dmem_addr  = mem_alu_result;
    assign dmem_wdata = mem_rt_data;

    assign timeout_fire = (state == ST_WAIT) && dmem_req && !dmem_ack
                          && (wait_cnt == WAIT_LAST);
    assign mem_stall    = dmem_req && !dmem_ack && !timeout_fire;
    assign fault        = misaligned || timeout_fire;
    // Ack only counts against a live request, so a late ack in IDLE is dropped.
    assign read_done    = dmem_req && dmem_ack && !mem_memwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (dmem_req && !dmem_ack) begin
                state    <= ST_WAIT;
                wait_cnt <= '0;
            end
        end else begin
            if (!dmem_req || dmem_ack || timeout_fire) begin
                state    <= ST_IDLE;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        wb_d            = '0;
        wb_d.regwrite   = mem_regwrite && !fault;
        wb_d.memtoreg   = mem_memtoreg;
        wb_d.alu_result = mem_alu_result;
        wb_d.mem_data   = read_done ? dmem_rdata : '0;
        wb_d.rd         = mem_rd;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk   (clk),
        .rst   (rst),
        .stall (mem_stall),
        .d     (wb_d),
        .q     (wb_q)
    );

    assign wb_regwrite   = wb_q.regwrite;
    assign wb_memtoreg   = wb_q.memtoreg;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_mem_data   = wb_q.mem_data;
    assign wb_rd         = wb_q.rd;

    // The faulting address holds after the pulse; only cause and pulse clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_exc       <= 1'b0;
            mem_exc_cause <= EXC_NONE;
            mem_exc_addr  <= '0;
        end else begin
            mem_exc <= fault;
            if (misaligned) begin
                mem_exc_cause <= EXC_MISALIGN;
            end else if (timeout_fire) begin
                mem_exc_cause <= EXC_BUSTO;
            end else begin
                mem_exc_cause <= EXC_NONE;
            end
            if (fault) begin
                mem_exc_addr <= mem_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage with TIMEOUT_CYC = 4.
module tb_mem_stage;

    typedef struct {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [4:0]  rd;
        logic        exc;
        logic [1:0]  cause;
        logic [31:0] eaddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
    logic [31:0] mem_alu_result, mem_rt_data;
    logic [4:0]  mem_rd;
    logic        dmem_req, dmem_we, dmem_ack, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_regwrite, wb_memtoreg, mem_exc;
    logic [31:0] wb_alu_result, wb_mem_data, mem_exc_addr;
    logic [4:0]  wb_rd;
    logic [1:0]  mem_exc_cause;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t last;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_alu_result(mem_alu_result), .mem_rt_data(mem_rt_data), .mem_rd(mem_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_rd(wb_rd),
        .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause), .mem_exc_addr(mem_exc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [4:0] rd, input logic ack, input logic [31:0] rdata);
        rst = r; mem_regwrite = rw; mem_memread = mr; mem_memwrite = mw;
        mem_memtoreg = m2r; mem_alu_result = alu; mem_rt_data = rt; mem_rd = rd;
        dmem_ack = ack; dmem_rdata = rdata;
    endtask

    function automatic exp_t mk(input logic rw, input logic m2r, input logic [31:0] alu,
                                input logic [31:0] md, input logic [4:0] rd,
                                input logic exc, input logic [1:0] cause);
        exp_t e;
        e.regwrite = rw; e.memtoreg = m2r; e.alu = alu; e.mdata = md; e.rd = rd;
        e.exc = exc; e.cause = cause; e.eaddr = exc ? alu : 32'h0;
        return e;
    endfunction

    function automatic exp_t bubble(input exp_t prev);
        exp_t e;
        e = prev;
        e.regwrite = 1'b0; e.exc = 1'b0; e.cause = 2'b00;
        return e;
    endfunction

    // One clock: combinational checks at the falling edge, registered checks 1ns after the rising edge.
    task automatic cyc(input string tag, input logic e_req, input logic e_stall, input exp_t e);
        exp_t got;
        #4;
        chk({tag, "_req"}, {31'b0, dmem_req}, {31'b0, e_req});
        chk({tag, "_stall"}, {31'b0, mem_stall}, {31'b0, e_stall});
        if (e_req) begin
            chk({tag, "_we"}, {31'b0, dmem_we}, {31'b0, mem_memwrite});
            chk({tag, "_addr"}, dmem_addr, mem_alu_result);
            chk({tag, "_wdata"}, dmem_wdata, mem_rt_data);
        end
        sb.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({tag, "_wb_regwrite"}, {31'b0, wb_regwrite}, {31'b0, got.regwrite});
            chk({tag, "_wb_memtoreg"}, {31'b0, wb_memtoreg}, {31'b0, got.memtoreg});
            chk({tag, "_wb_alu"}, wb_alu_result, got.alu);
            chk({tag, "_wb_mdata"}, wb_mem_data, got.mdata);
            chk({tag, "_wb_rd"}, {27'b0, wb_rd}, {27'b0, got.rd});
            chk({tag, "_exc"}, {31'b0, mem_exc}, {31'b0, got.exc});
            chk({tag, "_cause"}, {30'b0, mem_exc_cause}, {30'b0, got.cause});
            if (got.exc) chk({tag, "_eaddr"}, mem_exc_addr, got.eaddr);
        end
    endtask

    initial begin
        exp_t zero;
        zero = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        last = zero;

        // Reset with an aligned load presented: request and stall forced low.
        drv(1, 1, 1, 0, 1, 32'h100, 32'h0, 5'd5, 0, 32'h0);
        cyc("rst0", 0, 0, zero);
        cyc("rst1", 0, 0, zero);
        chk("rst_eaddr", mem_exc_addr, 32'h0);

        // Zero-wait load.
        drv(0, 1, 1, 0, 1, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF);
        cyc("ld0", 1, 0, mk(1, 1, 32'h100, 32'hDEADBEEF, 5'd5, 0, 2'b00));

        // Store acked on the fourth request cycle: three stalls, three bubbles.
        drv(0, 0, 0, 1, 0, 32'h204, 32'hCAFEF00D, 5'd0, 0, 32'h0);
        for (int i = 0; i < 3; i++) cyc("st_w", 1, 1, bubble(last));
        dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
        cyc("st_ack", 1, 0, mk(0, 0, 32'h204, 32'h0, 5'd0, 0, 2'b00));

        // Misaligned load: no request, no stall, fault pulse.
        drv(0, 1, 1, 0, 1, 32'h102, 32'h0, 5'd7, 0, 32'h0);
        cyc("mis", 0, 0, mk(0, 1, 32'h102, 32'h0, 5'd7, 1, 2'b01));

        // ALU op right after: pulse drops, faulting address holds.
        drv(0, 1, 0, 0, 0, 32'h55, 32'h0, 5'd3, 0, 32'h0);
        cyc("alu1", 0, 0, mk(1, 0, 32'h55, 32'h0, 5'd3, 0, 2'b00));
        chk("mis_eaddr_hold", mem_exc_addr, 32'h102);

        // Load never acked: four stall cycles, then the fire cycle without stall.
        drv(0, 1, 1, 0, 1, 32'h300, 32'h0, 5'd9, 0, 32'h0);
        for (int i = 0; i < 4; i++) cyc("to_w", 1, 1, bubble(last));
        cyc("to_fire", 1, 0, mk(0, 1, 32'h300, 32'h0, 5'd9, 1, 2'b10));

        // Stray ack with no access: ignored.
        drv(0, 1, 0, 0, 0, 32'h77, 32'h0, 5'd4, 1, 32'h1234);
        cyc("stray", 0, 0, mk(1, 0, 32'h77, 32'h0, 5'd4, 0, 2'b00));

        // Reset on the second WAIT cycle aborts the load with no exception.
        drv(0, 1, 1, 0, 1, 32'h400, 32'h0, 5'd8, 0, 32'h0);
        cyc("rw_idle", 1, 1, bubble(last));
        cyc("rw_w0", 1, 1, bubble(last));
        rst = 1'b1;
        cyc("rw_rst", 0, 0, zero);

        // Back-to-back ALU, zero-wait load, one-wait store: one bubble.
        drv(0, 1, 0, 0, 0, 32'h11, 32'h0, 5'd1, 0, 32'h0);
        cyc("b2b_alu", 0, 0, mk(1, 0, 32'h11, 32'h0, 5'd1, 0, 2'b00));
        drv(0, 1, 1, 0, 1, 32'h500, 32'h0, 5'd2, 1, 32'hA5A5A5A5);
        cyc("b2b_ld", 1, 0, mk(1, 1, 32'h500, 32'hA5A5A5A5, 5'd2, 0, 2'b00));
        drv(0, 0, 0, 1, 0, 32'h504, 32'h12345678, 5'd0, 0, 32'h0);
        cyc("b2b_st_w", 1, 1, bubble(last));
        dmem_ack = 1'b1;
        cyc("b2b_st_ack", 1, 0, mk(0, 0, 32'h504, 32'h0, 5'd0, 0, 2'b00));

        // Read and write both set: treated as a write, read data discarded.
        drv(0, 1, 1, 1, 1, 32'h600, 32'h87654321, 5'd6, 1, 32'hFFFF0000);
        cyc("rw_both", 1, 0, mk(1, 1, 32'h600, 32'h0, 5'd6, 0, 2'b00));

        drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        cyc("nop", 0, 0, mk(0, 0, 32'h0, 32'h0, 5'd0, 0, 2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
